pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Fetch sequencer for the processor's 16-bit program counter register, which has ld/inc/D controls, ld/inc mutual exclusion, and async clear. It drives that register's ld, inc and D, issues instruction reads, and strobes the instruction register. It hands each instruction to the execute stage, then applies branch redirects, interrupts and bus-timeout traps.

Parameters:
RESET_VEC, 16'h0000, PC loaded after reset
INT_VEC, 16'h0004, interrupt handler address
ERR_VEC, 16'h0008, bus-timeout trap address
TIMEOUT, 15, FETCH wait cycles without mem_ack before trap (range 1-255)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
pc_q  in  16  current PC register value
pc_ld  out  1  PC register load strobe
pc_inc  out  1  PC register increment strobe
pc_d  out  16  PC register load data
mem_rd  out  1  instruction read request
mem_addr  out  16  read address (equals pc_q)
mem_ack  in  1  read data valid this cycle
ir_ld  out  1  capture instruction word into IR
ir_valid  out  1  IR holds an instruction for execute
exec_done  in  1  execute stage finished current instruction
br_take  in  1  redirect (qualified by exec_done)
br_target  in  16  absolute redirect address
halt  in  1  halt after current instruction (qualified by exec_done)
int_req  in  1  level interrupt request
ie_set  in  1  set interrupt enable (used by return-from-interrupt)
int_ack  out  1  one-cycle pulse on interrupt entry
ie  out  1  interrupt enable flag
epc  out  16  saved return address
bus_err  out  1  sticky timeout flag
state  out  3  FSM state, debug

Behaviour:
- Reset (reset_n low, async): state=BOOT, ie=0, epc=0, bus_err=0, timeout counter=0. All strobes (pc_ld, pc_inc, mem_rd, ir_ld, ir_valid, int_ack) are forced 0 while reset_n is low, regardless of state.
- Strobes are combinational decodes of registered state and inputs. pc_ld and pc_inc are never high together. pc_d=0 whenever pc_ld=0.
- State encoding: BOOT=0, FETCH=1, EXEC=2, TRAP=3, HALT=4.
- BOOT: pc_ld=1, pc_d=RESET_VEC. Go to FETCH next cycle.
- FETCH: mem_rd=1, mem_addr=pc_q.
  - mem_ack: ir_ld=1 and pc_inc=1 in the same cycle, counter cleared, go to EXEC. Fetch latency = 1 cycle + memory wait.
  - no ack: counter increments. At TIMEOUT consecutive non-ack cycles: bus_err<=1, epc<=pc_q, ie<=0, go to TRAP with vector ERR_VEC.
- EXEC: ir_valid=1. Hold until exec_done. On exec_done, priority is:
  1. int_req&&ie: epc<=(br_take?br_target:pc_q), ie<=0, int_ack=1, go to TRAP with vector INT_VEC.
  2. br_take: pc_ld=1, pc_d=br_target, go to FETCH.
  3. halt: go to HALT.
  4. otherwise: go to FETCH. PC already points at the next instruction.
- TRAP: pc_ld=1, pc_d=latched vector (ERR_VEC or INT_VEC). Go to FETCH. The trap costs exactly 1 cycle.
- HALT: no strobes. If int_req&&ie: epc<=pc_q, ie<=0, int_ack=1, go to TRAP with INT_VEC. Otherwise stay; only reset leaves HALT otherwise.
- ie_set: ie<=1 on any clock edge, except when the same edge clears ie for a trap entry (the clear wins).
- int_req outside EXEC/HALT is ignored until the next exec_done or HALT cycle. int_ack is never asserted twice for one entry.
- PC wrap: 16'hFFFF increments to 16'h0000, and this is not an error.
- bus_err stays set until reset. Repeated timeouts re-trap each time.

Test Plan:
- Reset then mem_ack on the 2nd FETCH cycle with instruction word 0x1234 → BOOT cycle pc_ld=1 with pc_d=0; ir_ld and pc_inc high together; PC becomes 0x0001; ir_valid high until exec_done.
- Straight-line code, 3 instructions, 1-cycle ack → PC goes 0→1→2→3; pc_ld never high after BOOT; pc_ld&&pc_inc never both high.
- In EXEC with pc_q=0x0011, exec_done+br_take with br_target=0x0040 → pc_ld=1, pc_d=0x0040; next FETCH has mem_addr=0x0040.
- ie_set, then int_req asserted mid-EXEC with pc_q=0x0021, exec_done+br_take with br_target=0x0050 → epc=0x0050, int_ack 1 cycle, ie=0, TRAP loads 0x0004; second int_req is ignored until ie_set.
- mem_ack withheld for TIMEOUT=15 cycles at pc_q=0x0100 → bus_err=1, epc=0x0100, PC=0x0008; reset_n pulsed low mid-FETCH → state=0, all strobes 0 immediately.
- halt with exec_done → HALT with no mem_rd; int_req with ie=0 → stays in HALT; with ie=1 → TRAP to 0x0004.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module   : pc_fetch_ctrl
// Brief    : Fetch sequencer driving PC ld/inc/D, instruction reads, IR strobe,
//            branch redirects, interrupt entry and bus-timeout traps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [15:0] INT_VEC   = 16'h0004,
  parameter logic [15:0] ERR_VEC   = 16'h0008,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc_q,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic [15:0] pc_d,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  output logic        ir_ld,
  output logic        ir_valid,
  input  logic        exec_done,
  input  logic        br_take,
  input  logic [15:0] br_target,
  input  logic        halt,
  input  logic        int_req,
  input  logic        ie_set,
  output logic        int_ack,
  output logic        ie,
  output logic [15:0] epc,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam logic [2:0] C_BOOT  = 3'd0;
  localparam logic [2:0] C_FETCH = 3'd1;
  localparam logic [2:0] C_EXEC  = 3'd2;
  localparam logic [2:0] C_TRAP  = 3'd3;
  localparam logic [2:0] C_HALT  = 3'd4;

  // Last wait count before the timeout trap fires on a further non-ack cycle.
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] epc_q, epc_d;
  logic        ie_q, ie_d;
  logic        berr_q, berr_d;
  logic        w_ie_clr;
  logic        w_irq;

  assign w_irq = int_req && ie_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= C_BOOT;
      cnt_q   <= 8'd0;
      vec_q   <= 16'h0000;
      epc_q   <= 16'h0000;
      ie_q    <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      epc_q   <= epc_d;
      ie_q    <= ie_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = 8'd0;
    vec_d    = vec_q;
    epc_d    = epc_q;
    berr_d   = berr_q;
    w_ie_clr = 1'b0;
    case (state_q)
      C_BOOT: state_d = C_FETCH;
      C_FETCH: begin
        if (mem_ack) begin
          state_d = C_EXEC;
        end else if (cnt_q == C_TO_LAST) begin
          state_d  = C_TRAP;
          vec_d    = ERR_VEC;
          epc_d    = pc_q;
          berr_d   = 1'b1;
          w_ie_clr = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      C_EXEC: begin
        if (exec_done) begin
          if (w_irq) begin
            state_d  = C_TRAP;
            vec_d    = INT_VEC;
            epc_d    = br_take ? br_target : pc_q;
            w_ie_clr = 1'b1;
          end else if (br_take) begin
            state_d = C_FETCH;
          end else if (halt) begin
            state_d = C_HALT;
          end else begin
            state_d = C_FETCH;
          end
        end
      end
      C_TRAP: state_d = C_FETCH;
      C_HALT: begin
        if (w_irq) begin
          state_d  = C_TRAP;
          vec_d    = INT_VEC;
          epc_d    = pc_q;
          w_ie_clr = 1'b1;
        end
      end
      default: state_d = C_BOOT;
    endcase
    // A trap entry clearing ie takes precedence over a same-edge ie_set.
    ie_d = w_ie_clr ? 1'b0 : (ie_set ? 1'b1 : ie_q);
  end

  always_comb begin
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_d     = 16'h0000;
    mem_rd   = 1'b0;
    ir_ld    = 1'b0;
    ir_valid = 1'b0;
    int_ack  = 1'b0;
    if (reset_n) begin
      case (state_q)
        C_BOOT: begin
          pc_ld = 1'b1;
          pc_d  = RESET_VEC;
        end
        C_FETCH: begin
          mem_rd = 1'b1;
          ir_ld  = mem_ack;
          pc_inc = mem_ack;
        end
        C_EXEC: begin
          ir_valid = 1'b1;
          int_ack  = exec_done && w_irq;
          if (exec_done && !w_irq && br_take) begin
            pc_ld = 1'b1;
            pc_d  = br_target;
          end
        end
        C_TRAP: begin
          pc_ld = 1'b1;
          pc_d  = vec_q;
        end
        C_HALT: int_ack = w_irq;
        default: ;
      endcase
    end
  end

  assign mem_addr = pc_q;
  assign ie       = ie_q;
  assign epc      = epc_q;
  assign bus_err  = berr_q;
  assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Brief    : Self-checking bench for pc_fetch_ctrl with a PC register model,
//            directed scenarios and randomized traffic against a reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

  localparam logic [15:0] RV = 16'h0000;
  localparam logic [15:0] IV = 16'h0004;
  localparam logic [15:0] EV = 16'h0008;
  localparam int          TO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc_q;
  logic        pc_ld, pc_inc, mem_rd, ir_ld, ir_valid, int_ack, ie, bus_err;
  logic [15:0] pc_d, mem_addr, epc;
  logic [2:0]  state;
  logic        mem_ack, exec_done, br_take, halt, int_req, ie_set;
  logic [15:0] br_target;

  int tests = 0;
  int fails = 0;

  pc_fetch_ctrl #(.RESET_VEC(RV), .INT_VEC(IV), .ERR_VEC(EV), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .pc_q(pc_q), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_d(pc_d), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .ir_ld(ir_ld), .ir_valid(ir_valid), .exec_done(exec_done), .br_take(br_take),
    .br_target(br_target), .halt(halt), .int_req(int_req), .ie_set(ie_set),
    .int_ack(int_ack), .ie(ie), .epc(epc), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // The external PC register: load wins, increment wraps, async clear.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pc_q <= 16'h0000;
    else if (pc_ld)  pc_q <= pc_d;
    else if (pc_inc) pc_q <= pc_q + 16'h0001;
  end

  // Reference model: phase names as plain ints, expected PC tracked directly.
  int          m_st, n_st, m_wait, n_wait;
  bit          m_ie, n_ie, m_berr, n_berr;
  logic [15:0] m_epc, n_epc, m_pc, n_pc, m_vec, n_vec;
  bit          e_pcld, e_pcinc, e_memrd, e_irld, e_irv, e_ack;
  logic [15:0] e_pcd;
  int          stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_wait = 0; m_ie = 0; m_berr = 0;
    m_epc = 16'h0; m_pc = 16'h0; m_vec = 16'h0;
  endtask

  task automatic trap_entry(input logic [15:0] ret, input logic [15:0] v);
    n_epc = ret; n_vec = v; n_st = 3;
    n_ie = 0;
  endtask

  task automatic model_eval();
    bit irq;
    e_pcld = 0; e_pcinc = 0; e_memrd = 0; e_irld = 0; e_irv = 0; e_ack = 0;
    e_pcd = 16'h0;
    n_st = m_st; n_wait = 0; n_ie = ie_set ? 1'b1 : m_ie; n_berr = m_berr;
    n_epc = m_epc; n_pc = m_pc; n_vec = m_vec;
    irq = int_req && m_ie;
    case (m_st)
      0: begin e_pcld = 1; e_pcd = RV; n_pc = RV; n_st = 1; end
      1: begin
        e_memrd = 1;
        if (mem_ack) begin
          e_irld = 1; e_pcinc = 1; n_pc = m_pc + 16'h1; n_st = 2;
        end else if (m_wait + 1 == TO) begin
          n_berr = 1; trap_entry(m_pc, EV);
        end else begin
          n_wait = m_wait + 1;
        end
      end
      2: begin
        e_irv = 1;
        if (exec_done) begin
          if (irq) begin
            e_ack = 1; trap_entry(br_take ? br_target : m_pc, IV);
          end else if (br_take) begin
            e_pcld = 1; e_pcd = br_target; n_pc = br_target; n_st = 1;
          end else n_st = halt ? 4 : 1;
        end
      end
      3: begin e_pcld = 1; e_pcd = m_vec; n_pc = m_vec; n_st = 1; end
      default: if (irq) begin e_ack = 1; trap_entry(m_pc, IV); end
    endcase
  endtask

  task automatic step();
    #1;
    model_eval();
    chk("state", state, m_st);
    chk("pc_ld", pc_ld, e_pcld);
    chk("pc_inc", pc_inc, e_pcinc);
    chk("pc_d", pc_d, e_pcd);
    chk("mem_rd", mem_rd, e_memrd);
    chk("mem_addr", mem_addr, m_pc);
    chk("ir_ld", ir_ld, e_irld);
    chk("ir_valid", ir_valid, e_irv);
    chk("int_ack", int_ack, e_ack);
    chk("ie", ie, m_ie);
    chk("epc", epc, m_epc);
    chk("bus_err", bus_err, m_berr);
    chk("ld_inc_excl", pc_ld && pc_inc, 1'b0);
    @(posedge clk);
    m_st = n_st; m_wait = n_wait; m_ie = n_ie; m_berr = n_berr;
    m_epc = n_epc; m_pc = n_pc; m_vec = n_vec;
    @(negedge clk);
  endtask

  task automatic set_in(input bit ack, input bit done, input bit br, input logic [15:0] tgt,
                        input bit hlt, input bit irq, input bit ies);
    mem_ack = ack; exec_done = done; br_take = br; br_target = tgt;
    halt = hlt; int_req = irq; ie_set = ies;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_strobes", {pc_ld, pc_inc, mem_rd, ir_ld, ir_valid, int_ack}, 6'b0);
    chk("rst_flags", {ie, bus_err}, 2'b0);
    chk("rst_epc", epc, 16'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 16'h0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Boot, then ack on the second fetch cycle.
    set_in(0, 0, 0, 16'h0, 0, 0, 0); #1;
    chk("boot_state", state, 0); chk("boot_pc_ld", pc_ld, 1); chk("boot_pc_d", pc_d, 16'h0000);
    step();
    #1; chk("fetch1_rd", mem_rd, 1); chk("fetch1_irld", ir_ld, 0);
    step();
    set_in(1, 0, 0, 16'h0, 0, 0, 0); #1;
    chk("fetch2_irld_inc", {ir_ld, pc_inc, pc_ld}, 3'b110);
    step();
    set_in(0, 0, 0, 16'h0, 0, 0, 0); #1;
    chk("exec_valid", ir_valid, 1); chk("exec_pc", mem_addr, 16'h0001);
    step(); step();

    // Straight-line code.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 16'h0, 0, 0, 0); step();
      set_in(1, 0, 0, 16'h0, 0, 0, 0); step();
    end
    set_in(0, 0, 0, 16'h0, 0, 0, 0); #1; chk("straight_pc", mem_addr, 16'h0004);

    // Branch from 0x0011 to 0x0040, then a branch that wraps the PC.
    set_in(0, 1, 1, 16'h0010, 0, 0, 0); step();
    set_in(1, 0, 0, 16'h0, 0, 0, 0); step();
    set_in(0, 1, 1, 16'h0040, 0, 0, 0); #1;
    chk("br_pc_at", mem_addr, 16'h0011); chk("br_ld", pc_ld, 1); chk("br_d", pc_d, 16'h0040);
    step();
    set_in(1, 0, 0, 16'h0, 0, 0, 0); #1; chk("br_fetch_addr", mem_addr, 16'h0040);
    step();
    set_in(0, 1, 1, 16'hFFFF, 0, 0, 0); step();
    set_in(1, 0, 0, 16'h0, 0, 0, 0); step();
    set_in(0, 0, 0, 16'h0, 0, 0, 0); #1; chk("wrap_pc", mem_addr, 16'h0000);

    // Interrupt taken together with a branch.
    set_in(0, 1, 1, 16'h0020, 0, 0, 0); step();
    set_in(1, 0, 0, 16'h0, 0, 0, 0); step();
    set_in(0, 0, 0, 16'h0, 0, 0, 1); step();
    set_in(0, 0, 0, 16'h0, 0, 1, 0); step();
    set_in(0, 1, 1, 16'h0050, 0, 1, 0); #1;
    chk("irq_ack", int_ack, 1); chk("irq_no_ld", pc_ld, 0); chk("irq_pc_at", mem_addr, 16'h0021);
    step();
    set_in(0, 0, 0, 16'h0, 0, 1, 0); #1;
    chk("irq_epc", epc, 16'h0050); chk("irq_ie", ie, 0); chk("irq_trap", state, 3);
    chk("irq_vec", pc_d, 16'h0004); chk("irq_ack_once", int_ack, 0);
    step();
    set_in(1, 0, 0, 16'h0, 0, 1, 0); step();
    set_in(0, 1, 0, 16'h0, 0, 1, 0); #1; chk("irq_masked", int_ack, 0);
    step();

    // Bus timeout at 0x0100, then reset in the middle of a fetch.
    set_in(1, 0, 0, 16'h0, 0, 0, 0); step();
    set_in(0, 1, 1, 16'h0100, 0, 0, 0); step();
    set_in(0, 0, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step();
    #1; chk("to_still_fetch", state, 1);
    step();
    #1; chk("to_trap", state, 3); chk("to_berr", bus_err, 1); chk("to_epc", epc, 16'h0100);
    step();
    #1; chk("to_vec_pc", mem_addr, 16'h0008); chk("to_refetch", state, 1);
    step(); step();
    do_reset();

    // Halt, masked interrupt, then enabled interrupt.
    set_in(0, 0, 0, 16'h0, 0, 0, 0); step();
    set_in(1, 0, 0, 16'h0, 0, 0, 0); step();
    set_in(0, 1, 0, 16'h0, 1, 0, 0); step();
    set_in(0, 0, 0, 16'h0, 0, 1, 0); #1; chk("halt_state", state, 4); chk("halt_no_rd", mem_rd, 0);
    repeat (3) step();
    #1; chk("halt_masked", state, 4);
    set_in(0, 0, 0, 16'h0, 0, 0, 1); step();
    set_in(0, 0, 0, 16'h0, 0, 1, 0); #1; chk("halt_irq_ack", int_ack, 1);
    step();
    #1; chk("halt_trap", state, 3); chk("halt_vec", pc_d, 16'h0004);
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      if (stall > 0) begin
        mem_ack = 1'b0; stall--;
      end else begin
        mem_ack = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 149) == 0) stall = 20;
      end
      exec_done = $urandom_range(0, 1) != 0;
      br_take   = $urandom_range(0, 9) < 3;
      br_target = 16'($urandom);
      halt      = $urandom_range(0, 19) == 0;
      int_req   = $urandom_range(0, 4) == 0;
      ie_set    = $urandom_range(0, 9) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
